// File: rtl/y86_mc_ctrl_if.sv
// Handshake and status bundle between the Y86 multi-cycle controller and the datapath.
// The master modport is the controller side; the slave modport is the datapath/memory side.
interface y86_mc_ctrl_if #(
    parameter int CNT_WID = 32
);
    logic [3:0]         icode;
    logic               instr_valid;
    logic               imem_error;
    logic               mem_ready;
    logic               dmem_error;
    logic               fetch_en;
    logic               decode_en;
    logic               exec_en;
    logic               mem_req;
    logic               mem_write;
    logic               wb_en;
    logic               pc_en;
    logic [3:0]         stat;
    logic               halted;
    logic [CNT_WID-1:0] retired;
    logic [CNT_WID-1:0] cycles;

    modport master (
        input  icode, instr_valid, imem_error, mem_ready, dmem_error,
        output fetch_en, decode_en, exec_en, mem_req, mem_write, wb_en, pc_en,
        output stat, halted, retired, cycles
    );

    modport slave (
        output icode, instr_valid, imem_error, mem_ready, dmem_error,
        input  fetch_en, decode_en, exec_en, mem_req, mem_write, wb_en, pc_en,
        input  stat, halted, retired, cycles
    );
endinterface

// File: rtl/y86_mc_ctrl.sv
// Multi-cycle sequencer for the Y86 datapath: stage enables, bounded data-memory
// handshake, per-icode stage skipping, sticky status and retire/cycle counters.
module y86_mc_ctrl #(
    parameter int DATA_WID = 32,
    parameter int CNT_WID  = 32,
    parameter int MAX_WAIT = 15
) (
    input logic           CLK,
    input logic           RST,
    y86_mc_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_PCUPD,
        S_HALT
    } state_t;

    localparam logic [3:0] STAT_AOK = 4'd1;
    localparam logic [3:0] STAT_HLT = 4'd2;
    localparam logic [3:0] STAT_ADR = 4'd3;
    localparam logic [3:0] STAT_INS = 4'd4;

    // wait_cnt only has to reach MAX_WAIT-1 before the timeout fires
    localparam int                  WAIT_WID  = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_WID-1:0] WAIT_LAST = WAIT_WID'(MAX_WAIT - 1);

    if (MAX_WAIT < 1 || DATA_WID < 1) begin : g_param_check
        $error("y86_mc_ctrl: MAX_WAIT and DATA_WID must be at least 1");
    end

    state_t              state, state_n;
    logic [3:0]          stat_q, stat_n;
    logic [3:0]          icode_q;
    logic [WAIT_WID-1:0] wait_cnt;
    logic [CNT_WID-1:0]  retired_q;
    logic [CNT_WID-1:0]  cycles_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_FETCH;
            stat_q    <= STAT_AOK;
            icode_q   <= '0;
            wait_cnt  <= '0;
            retired_q <= '0;
            cycles_q  <= '0;
        end else begin
            state  <= state_n;
            stat_q <= stat_n;
            if (state == S_FETCH)
                icode_q <= bus.icode;
            if (state == S_MEMORY && !bus.mem_ready)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (state == S_PCUPD)
                retired_q <= retired_q + 1'b1;
            if (state != S_HALT)
                cycles_q <= cycles_q + 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        stat_n  = stat_q;
        unique case (state)
            S_FETCH: begin
                if (bus.imem_error) begin
                    state_n = S_HALT;
                    stat_n  = STAT_ADR;
                end else if (!bus.instr_valid) begin
                    state_n = S_HALT;
                    stat_n  = STAT_INS;
                end else begin
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                if (icode_q == 4'h0) begin
                    state_n = S_HALT;
                    stat_n  = STAT_HLT;
                end else begin
                    state_n = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (icode_q inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB})
                    state_n = S_MEMORY;
                else if (icode_q inside {4'h2, 4'h3, 4'h6})
                    state_n = S_WRITEBACK;
                else
                    state_n = S_PCUPD;
            end
            S_MEMORY: begin
                if (bus.mem_ready) begin
                    if (bus.dmem_error) begin
                        state_n = S_HALT;
                        stat_n  = STAT_ADR;
                    end else if (icode_q inside {4'h5, 4'h8, 4'h9, 4'hA, 4'hB}) begin
                        state_n = S_WRITEBACK;
                    end else begin
                        state_n = S_PCUPD;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    state_n = S_HALT;
                    stat_n  = STAT_ADR;
                end
            end
            S_WRITEBACK: state_n = S_PCUPD;
            S_PCUPD:     state_n = S_FETCH;
            S_HALT:      state_n = S_HALT;
            default:     state_n = S_HALT;
        endcase
    end

    always_comb begin
        bus.fetch_en  = (state == S_FETCH);
        bus.decode_en = (state == S_DECODE);
        bus.exec_en   = (state == S_EXECUTE);
        bus.mem_req   = (state == S_MEMORY);
        bus.mem_write = (state == S_MEMORY) && (icode_q inside {4'h4, 4'h8, 4'hA});
        bus.wb_en     = (state == S_WRITEBACK);
        bus.pc_en     = (state == S_PCUPD);
        bus.halted    = (state == S_HALT);
        bus.stat      = stat_q;
        bus.retired   = retired_q;
        bus.cycles    = cycles_q;
    end
endmodule

// File: tb/tb_y86_mc_ctrl.sv
// Directed bench for y86_mc_ctrl: one MAX_WAIT=15 instance plus a MAX_WAIT=1 instance
// sharing clock, reset and inputs, checked against hand-computed cycle sequences.
module tb_y86_mc_ctrl;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 CLK = ~CLK;

    y86_mc_ctrl_if #(.CNT_WID(32)) bus  ();
    y86_mc_ctrl_if #(.CNT_WID(32)) bus1 ();

    assign bus1.icode       = bus.icode;
    assign bus1.instr_valid = bus.instr_valid;
    assign bus1.imem_error  = bus.imem_error;
    assign bus1.mem_ready   = bus.mem_ready;
    assign bus1.dmem_error  = bus.dmem_error;

    y86_mc_ctrl #(.DATA_WID(32), .CNT_WID(32), .MAX_WAIT(15)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    y86_mc_ctrl #(.DATA_WID(32), .CNT_WID(32), .MAX_WAIT(1)) dut1 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus1)
    );

    // {fetch, decode, exec, mem_req, mem_write, wb, pc}
    function automatic logic [6:0] en_vec();
        return {bus.fetch_en, bus.decode_en, bus.exec_en, bus.mem_req,
                bus.mem_write, bus.wb_en, bus.pc_en};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic set_in(input logic [3:0] ic, input logic iv, input logic ie,
                          input logic rdy, input logic de);
        bus.icode       = ic;
        bus.instr_valid = iv;
        bus.imem_error  = ie;
        bus.mem_ready   = rdy;
        bus.dmem_error  = de;
    endtask

    task automatic test_reset();
        set_in(4'h1, 1'b1, 1'b0, 1'b1, 1'b0);
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        n_checks++;
        if (en_vec() !== 7'b1000000) begin
            n_fail++; $display("FAIL reset_enables: got %b expected %b", en_vec(), 7'b1000000);
        end
        n_checks++;
        if (bus.stat !== 4'd1) begin
            n_fail++; $display("FAIL reset_stat: got %0d expected 1", bus.stat);
        end
        n_checks++;
        if (bus.retired !== 32'd0 || bus.cycles !== 32'd0) begin
            n_fail++; $display("FAIL reset_counters: got retired=%0d cycles=%0d expected 0/0", bus.retired, bus.cycles);
        end
        n_checks++;
        if (bus.halted !== 1'b0 || bus1.halted !== 1'b0) begin
            n_fail++; $display("FAIL reset_halted: got %b/%b expected 0/0", bus.halted, bus1.halted);
        end
    endtask

    task automatic test_opq_nop();
        logic [6:0] exp_v [9];
        exp_v = '{7'b1000000, 7'b0100000, 7'b0010000, 7'b0000010, 7'b0000001,
                  7'b1000000, 7'b0100000, 7'b0010000, 7'b0000001};
        do_reset();
        set_in(4'h6, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            bus.icode = (i < 5) ? 4'h6 : 4'h1;
            n_checks++;
            if (en_vec() !== exp_v[i]) begin
                n_fail++; $display("FAIL opq_nop_enables cyc %0d: got %b expected %b", i, en_vec(), exp_v[i]);
            end
            tick();
        end
        n_checks++;
        if (bus.retired !== 32'd2 || bus.cycles !== 32'd9) begin
            n_fail++; $display("FAIL opq_nop_counters: got retired=%0d cycles=%0d expected 2/9", bus.retired, bus.cycles);
        end
        n_checks++;
        if (bus.stat !== 4'd1 || bus.fetch_en !== 1'b1) begin
            n_fail++; $display("FAIL opq_nop_stat: got stat=%0d fetch_en=%b expected 1/1", bus.stat, bus.fetch_en);
        end
    endtask

    task automatic test_mrmovq_wait();
        logic [6:0] exp_v [9];
        int         req_cnt;
        exp_v = '{7'b1000000, 7'b0100000, 7'b0010000, 7'b0001000, 7'b0001000,
                  7'b0001000, 7'b0001000, 7'b0000010, 7'b0000001};
        req_cnt = 0;
        do_reset();
        set_in(4'h5, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            bus.mem_ready = (i == 6);
            if (bus.mem_req) req_cnt++;
            n_checks++;
            if (en_vec() !== exp_v[i]) begin
                n_fail++; $display("FAIL mrmovq_enables cyc %0d: got %b expected %b", i, en_vec(), exp_v[i]);
            end
            if (i == 4) begin
                n_checks++;
                if (bus1.stat !== 4'd3 || bus1.halted !== 1'b1) begin
                    n_fail++; $display("FAIL max_wait1_timeout: got stat=%0d halted=%b expected 3/1", bus1.stat, bus1.halted);
                end
            end
            tick();
        end
        n_checks++;
        if (req_cnt != 4) begin
            n_fail++; $display("FAIL mrmovq_req_len: got %0d expected 4", req_cnt);
        end
        n_checks++;
        if (en_vec() !== 7'b1000000 || bus.retired !== 32'd1 || bus.cycles !== 32'd9) begin
            n_fail++; $display("FAIL mrmovq_done: got en=%b retired=%0d cycles=%0d expected 1000000/1/9", en_vec(), bus.retired, bus.cycles);
        end
    endtask

    task automatic test_pushq_timeout();
        int req_cnt, pc_cnt, wr_bad;
        req_cnt = 0;
        pc_cnt  = 0;
        wr_bad  = 0;
        do_reset();
        set_in(4'hA, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 25; i++) begin
            if (bus.mem_req) req_cnt++;
            if (bus.mem_req && !bus.mem_write) wr_bad++;
            if (bus.pc_en) pc_cnt++;
            tick();
        end
        n_checks++;
        if (req_cnt != 15) begin
            n_fail++; $display("FAIL pushq_req_len: got %0d expected 15", req_cnt);
        end
        n_checks++;
        if (wr_bad != 0 || pc_cnt != 0) begin
            n_fail++; $display("FAIL pushq_write_pc: got read_cycles=%0d pc_pulses=%0d expected 0/0", wr_bad, pc_cnt);
        end
        n_checks++;
        if (bus.stat !== 4'd3 || bus.halted !== 1'b1 || bus.retired !== 32'd0) begin
            n_fail++; $display("FAIL pushq_halt: got stat=%0d halted=%b retired=%0d expected 3/1/0", bus.stat, bus.halted, bus.retired);
        end
        n_checks++;
        if (bus.cycles !== 32'd18) begin
            n_fail++; $display("FAIL pushq_cycles: got %0d expected 18", bus.cycles);
        end
    endtask

    task automatic test_halt();
        do_reset();
        set_in(4'h1, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            bus.icode = (i < 8) ? 4'h1 : 4'h0;
            if (i == 9) begin
                n_checks++;
                if (bus.halted !== 1'b0 || bus.stat !== 4'd1 || bus.decode_en !== 1'b1) begin
                    n_fail++; $display("FAIL halt_decode: got halted=%b stat=%0d decode_en=%b expected 0/1/1", bus.halted, bus.stat, bus.decode_en);
                end
            end
            tick();
        end
        n_checks++;
        if (bus.stat !== 4'd2 || bus.halted !== 1'b1 || bus.retired !== 32'd2) begin
            n_fail++; $display("FAIL halt_state: got stat=%0d halted=%b retired=%0d expected 2/1/2", bus.stat, bus.halted, bus.retired);
        end
        n_checks++;
        if (bus.cycles !== 32'd10) begin
            n_fail++; $display("FAIL halt_cycles: got %0d expected 10", bus.cycles);
        end
        repeat (5) tick();
        n_checks++;
        if (bus.cycles !== 32'd10 || bus.halted !== 1'b1 || en_vec() !== 7'b0000000) begin
            n_fail++; $display("FAIL halt_sticky: got cycles=%0d halted=%b en=%b expected 10/1/0000000", bus.cycles, bus.halted, en_vec());
        end
    endtask

    task automatic test_reset_in_halt();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        n_checks++;
        if (bus.fetch_en !== 1'b1 || bus.stat !== 4'd1 || bus.halted !== 1'b0 ||
            bus.retired !== 32'd0 || bus.cycles !== 32'd0) begin
            n_fail++; $display("FAIL reset_from_halt: got fetch_en=%b stat=%0d halted=%b retired=%0d cycles=%0d expected 1/1/0/0/0",
                               bus.fetch_en, bus.stat, bus.halted, bus.retired, bus.cycles);
        end
    endtask

    task automatic test_ins_fault();
        int dec_cnt;
        dec_cnt = 0;
        do_reset();
        set_in(4'h6, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (bus.decode_en) dec_cnt++;
            tick();
        end
        n_checks++;
        if (bus.stat !== 4'd4 || bus.halted !== 1'b1 || dec_cnt != 0) begin
            n_fail++; $display("FAIL ins_fault: got stat=%0d halted=%b decodes=%0d expected 4/1/0", bus.stat, bus.halted, dec_cnt);
        end
        dec_cnt = 0;
        do_reset();
        set_in(4'h6, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (bus.decode_en) dec_cnt++;
            tick();
        end
        n_checks++;
        if (bus.stat !== 4'd3 || bus.halted !== 1'b1 || dec_cnt != 0) begin
            n_fail++; $display("FAIL imem_priority: got stat=%0d halted=%b decodes=%0d expected 3/1/0", bus.stat, bus.halted, dec_cnt);
        end
        set_in(4'h1, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_dmem_error();
        int late_cnt;
        late_cnt = 0;
        do_reset();
        set_in(4'h9, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            if (bus.wb_en || bus.pc_en) late_cnt++;
            tick();
        end
        n_checks++;
        if (bus.stat !== 4'd3 || bus.halted !== 1'b1 || bus.retired !== 32'd0 || late_cnt != 0) begin
            n_fail++; $display("FAIL dmem_error: got stat=%0d halted=%b retired=%0d wb_pc=%0d expected 3/1/0/0",
                               bus.stat, bus.halted, bus.retired, late_cnt);
        end
        bus.dmem_error = 1'b0;
    endtask

    task automatic test_max_wait_one();
        do_reset();
        set_in(4'h8, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (6) tick();
        n_checks++;
        if (bus1.retired !== 32'd1 || bus1.stat !== 4'd1 || bus1.fetch_en !== 1'b1) begin
            n_fail++; $display("FAIL max_wait1_ready: got retired=%0d stat=%0d fetch_en=%b expected 1/1/1", bus1.retired, bus1.stat, bus1.fetch_en);
        end
        n_checks++;
        if (bus.retired !== 32'd1 || bus.cycles !== 32'd6) begin
            n_fail++; $display("FAIL call_ready: got retired=%0d cycles=%0d expected 1/6", bus.retired, bus.cycles);
        end
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        set_in(4'h1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            bus.icode = (i < 4) ? 4'h1 : 4'h4;
            tick();
        end
        n_checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_write !== 1'b1 || bus.retired !== 32'd1) begin
            n_fail++; $display("FAIL rmmovq_2nd_mem: got mem_req=%b mem_write=%b retired=%0d expected 1/1/1", bus.mem_req, bus.mem_write, bus.retired);
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        n_checks++;
        if (bus.mem_req !== 1'b0 || bus.fetch_en !== 1'b1 || bus.stat !== 4'd1 ||
            bus.retired !== 32'd0 || bus.cycles !== 32'd0) begin
            n_fail++; $display("FAIL reset_mid_mem: got mem_req=%b fetch_en=%b stat=%0d retired=%0d cycles=%0d expected 0/1/1/0/0",
                               bus.mem_req, bus.fetch_en, bus.stat, bus.retired, bus.cycles);
        end
    endtask

    initial begin
        test_reset();
        test_opq_nop();
        test_mrmovq_wait();
        test_pushq_timeout();
        test_halt();
        test_reset_in_halt();
        test_ins_fault();
        test_dmem_error();
        test_max_wait_one();
        test_reset_mid_mem();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
